// File: rtl/l1_mem_arbiter_pkg.sv
// Shared constants for the L1 memory arbiter: cache geometry, FSM states, owner encoding.
package l1_mem_arbiter_pkg;

    localparam int unsigned L1_BLOCK_WORDS = 4;
    localparam int unsigned L1_WORD_BITS   = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    // Request attributes latched at grant
    typedef struct packed {
        owner_e      owner;
        logic        we;
        logic [31:0] base;
    } xfer_req_t;

endpackage

// File: rtl/l1_mem_arbiter_arb.sv
// Two-requester round-robin picker; bit 0 = I-cache, bit 1 = D-cache.
module arb_rr2
    import l1_mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid_c,
    output logic       owner_c
);

    always_comb begin
        grant_valid_c = |req;
        owner_c       = OWN_I;
        if (req == 2'b11) begin
            owner_c = ~last_grant;
        end else if (req[1]) begin
            owner_c = OWN_D;
        end
    end

endmodule

// File: rtl/l1_mem_arbiter.sv
// Shares one word-wide memory port between I- and D-cache refill paths,
// moving whole blocks as word-serial bursts with a one-cycle acknowledge.
module l1_mem_arbiter
    import l1_mem_arbiter_pkg::*;
#(
    parameter  int unsigned BLOCK_WORDS = L1_BLOCK_WORDS,
    localparam int unsigned BW          = L1_WORD_BITS * BLOCK_WORDS,
    localparam int unsigned OFF         = $clog2(BLOCK_WORDS) + 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_req,
    input  logic [31:0]   i_addr,
    output logic          i_ack,
    output logic [BW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [31:0]   d_addr,
    input  logic [BW-1:0] d_wdata,
    output logic          d_ack,
    output logic [BW-1:0] d_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_ready,
    output logic          busy
);

    localparam int unsigned IDX_W = $clog2(BLOCK_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_WORDS - 1);

    arb_state_e state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    owner_e last_grant_q;
    xfer_req_t xreq_q;
    logic [BLOCK_WORDS-1:0][31:0] wdata_q;
    logic [BLOCK_WORDS-1:0][31:0] i_rdata_q;
    logic [BLOCK_WORDS-1:0][31:0] d_rdata_q;

    logic grant_valid_c;
    logic grant_owner_c;
    logic [31:0] grant_addr_c;

    // Block-offset address bits are deliberately ignored
    logic unused_offset_bits;
    assign unused_offset_bits = ^{i_addr[OFF-1:0], d_addr[OFF-1:0]};

    arb_rr2 u_arb (
        .req           ({d_req, i_req}),
        .last_grant    (last_grant_q),
        .grant_valid_c (grant_valid_c),
        .owner_c       (grant_owner_c)
    );

    assign grant_addr_c = (grant_owner_c == OWN_D) ? d_addr : i_addr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and memory/ack outputs
    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        i_ack     = 1'b0;
        d_ack     = 1'b0;
        busy      = 1'b1;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (grant_valid_c) begin
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                mem_req   = 1'b1;
                mem_we    = xreq_q.we;
                mem_addr  = xreq_q.base + 32'({idx_q, 2'b00});
                mem_wdata = xreq_q.we ? wdata_q[idx_q] : 32'h0;
                if (mem_ready && (idx_q == LAST_IDX)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                i_ack   = (xreq_q.owner == OWN_I);
                d_ack   = (xreq_q.owner == OWN_D);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Grant latch, word index and read-block capture
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx_q        <= '0;
            last_grant_q <= OWN_I;
            xreq_q       <= '0;
            wdata_q      <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_valid_c) begin
                        xreq_q.owner <= owner_e'(grant_owner_c);
                        xreq_q.we    <= (grant_owner_c == OWN_D) ? d_we : 1'b0;
                        xreq_q.base  <= {grant_addr_c[31:OFF], {OFF{1'b0}}};
                        last_grant_q <= owner_e'(grant_owner_c);
                        idx_q        <= '0;
                        if (grant_owner_c == OWN_D) begin
                            wdata_q <= d_wdata;
                        end
                    end
                end
                ST_XFER: begin
                    if (mem_ready) begin
                        if (!xreq_q.we) begin
                            if (xreq_q.owner == OWN_D) begin
                                d_rdata_q[idx_q] <= mem_rdata;
                            end else begin
                                i_rdata_q[idx_q] <= mem_rdata;
                            end
                        end
                        if (idx_q != LAST_IDX) begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Randomized scoreboard bench for l1_mem_arbiter against a transaction-level model.
module tb_l1_mem_arbiter;
    import l1_mem_arbiter_pkg::*;

    localparam int unsigned NW = L1_BLOCK_WORDS;
    localparam int unsigned BW = 32 * NW;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          i_req = 1'b0;
    logic [31:0]   i_addr = '0;
    logic          i_ack;
    logic [BW-1:0] i_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [31:0]   d_addr = '0;
    logic [BW-1:0] d_wdata = '0;
    logic          d_ack;
    logic [BW-1:0] d_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          mem_ready = 1'b0;
    logic          busy;

    l1_mem_arbiter dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .busy(busy)
    );

    always #5 clock = ~clock;

    // Memory contents are a fixed function of the word address
    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction
    assign mem_rdata = memf(mem_addr);

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } acc_t;
    typedef struct {
        bit            own;
        logic [BW-1:0] data;
    } ack_t;

    acc_t accq[$];
    ack_t ackq[$];

    int tests = 0;
    int fails = 0;
    int i_done = 0;
    int d_done = 0;
    bit en = 1'b0;
    int raise_div = 1;
    int mode = 0;

    // Reference model state: words still to move, done-cycle flag, round-robin memory
    int m_left = 0;
    int m_tail = 0;
    bit m_last = 1'b0;
    bit m_owner = 1'b0;
    logic [BW-1:0] m_ird = '0;
    logic [BW-1:0] m_drd = '0;

    task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Transaction-level model: grants by the round-robin rule and queues expectations
    initial forever begin
        @(posedge clock or negedge reset);
        if (!reset) begin
            m_left = 0; m_tail = 0; m_last = 1'b0;
            m_ird = '0; m_drd = '0;
            accq.delete(); ackq.delete();
        end else if (m_left > 0) begin
            if (mem_ready) begin
                m_left--;
                if (m_left == 0) m_tail = 1;
            end
        end else if (m_tail > 0) begin
            m_tail = 0;
        end else if (i_req || d_req) begin
            bit own;
            logic [31:0] base;
            logic we;
            logic [BW-1:0] blk;
            own = (i_req && d_req) ? ~m_last : d_req;
            m_last = own;
            m_owner = own;
            base = (own ? d_addr : i_addr) & ~32'(NW * 4 - 1);
            we = own ? d_we : 1'b0;
            for (int k = 0; k < NW; k++) begin
                acc_t a;
                a.addr = base + 32'(4 * k);
                a.we = we;
                a.wdata = we ? d_wdata[32*k +: 32] : 32'h0;
                blk[32*k +: 32] = memf(a.addr);
                accq.push_back(a);
            end
            if (!we) begin
                if (own) m_drd = blk; else m_ird = blk;
            end
            ackq.push_back('{own, own ? m_drd : m_ird});
            m_left = NW;
        end
    end

    // Monitor: per-cycle protocol checks plus scoreboard pops on memory beats and acks
    initial forever begin
        @(negedge clock);
        if (!reset) begin
            chk("reset_ctl", BW'({i_ack, d_ack, mem_req, mem_we, busy, mem_addr, mem_wdata}), '0);
            chk("reset_rdata", i_rdata | d_rdata, '0);
        end else begin
            chk("mem_req", BW'(mem_req), BW'(m_left > 0));
            chk("busy", BW'(busy), BW'((m_left > 0) || (m_tail > 0)));
            chk("acks", BW'({i_ack, d_ack}),
                BW'({m_tail > 0 && !m_owner, m_tail > 0 && m_owner}));
            if (mem_req) begin
                if (accq.size() == 0) begin
                    chk("beat_unexpected", BW'(1), BW'(0));
                end else begin
                    chk("beat", BW'({mem_addr, mem_we, mem_wdata}),
                        BW'({accq[0].addr, accq[0].we, accq[0].wdata}));
                    if (mem_ready) void'(accq.pop_front());
                end
            end
            if (i_ack || d_ack) begin
                if (ackq.size() == 0) begin
                    chk("ack_unexpected", BW'(1), BW'(0));
                end else begin
                    ack_t e;
                    e = ackq.pop_front();
                    chk("ack_owner", BW'(d_ack), BW'(e.own));
                    chk("ack_rdata", e.own ? d_rdata : i_rdata, e.data);
                    chk("other_rdata", e.own ? i_rdata : d_rdata, e.own ? m_ird : m_drd);
                end
            end
        end
    end

    task automatic new_payload(input bit is_d);
        if (is_d) begin
            d_req = 1'b1;
            d_addr = $urandom();
            d_we = 1'($urandom_range(0, 1));
            for (int k = 0; k < NW; k++) d_wdata[32*k +: 32] = $urandom();
        end else begin
            i_req = 1'b1;
            i_addr = $urandom();
        end
    endtask

    task automatic drop(input bit is_d);
        if (is_d) d_req = 1'b0; else i_req = 1'b0;
    endtask

    // Requester: holds req until ack, sometimes chains a new request, churns inputs mid-flight
    task automatic drive(input bit is_d);
        bit active = 1'b0;
        forever begin
            @(posedge clock); #1;
            if (!reset) begin
                drop(is_d); active = 1'b0;
            end else if (active && (is_d ? d_ack : i_ack)) begin
                if (is_d) d_done++; else i_done++;
                if (en && $urandom_range(0, 1) == 1) new_payload(is_d);
                else begin drop(is_d); active = 1'b0; end
            end else if (!active && en && ($urandom() % raise_div) == 0) begin
                new_payload(is_d); active = 1'b1;
            end else if (active && $urandom_range(0, 7) == 0) begin
                new_payload(is_d);
            end
        end
    endtask

    initial drive(1'b0);
    initial drive(1'b1);

    initial forever begin
        @(posedge clock); #1;
        mem_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
    end

    initial begin
        bit ok;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        en = 1'b1; raise_div = 1; mode = 0;
        repeat (200) @(posedge clock);
        raise_div = 4; mode = 1;
        repeat (400) @(posedge clock);
        for (int r = 0; r < 3; r++) begin
            ok = 1'b0;
            for (int c = 0; c < 200 && !ok; c++) begin
                @(posedge clock); #2;
                ok = (m_left > 0) && (m_left < NW);
            end
            chk("reset_window_found", BW'(ok), BW'(1));
            reset = 1'b0;
            raise_div = 1;
            @(negedge clock);
            @(posedge clock); #2;
            reset = 1'b1;
            repeat (100) @(posedge clock);
            raise_div = 4;
        end
        raise_div = 3; mode = 0;
        repeat (200) @(posedge clock);
        en = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 500 && !ok; c++) begin
            @(posedge clock); #2;
            ok = !i_req && !d_req && m_left == 0 && m_tail == 0;
        end
        repeat (2) @(posedge clock);
        chk("drain", BW'(ok), BW'(1));
        chk("accq_empty", BW'(accq.size()), '0);
        chk("ackq_empty", BW'(ackq.size()), '0);
        chk("i_served", BW'(i_done > 0), BW'(1));
        chk("d_served", BW'(d_done > 0), BW'(1));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/l1_mem_arbiter.md
Name: l1_mem_arbiter

Overview:
Shares the single word-wide main-memory port between the L1 instruction-cache refill path and the L1 data-cache refill/writeback path. It arbitrates round-robin between the two caches and latches the winning request. It then sequences the block transfer as a word-serial burst and returns the whole block with a one-cycle acknowledge. It sits between the I-/D-caches (which stall the pipeline while req is pending) and main memory.

Parameters:
BLOCK_WORDS, 4, 32-bit words per cache block; power of two, >= 2.
BW, 32*BLOCK_WORDS, block width in bits (derived, not overridable).
OFF, log2(BLOCK_WORDS)+2, byte-offset bits within a block (derived).

Ports:
clock  input  1  clock
reset  input  1  reset, asynchronous, active-low
i_req  input  1  I-cache block read request; held until i_ack
i_addr  input  32  I-cache byte address (offset bits ignored)
i_ack  output  1  one-cycle pulse: I-cache transaction complete
i_rdata  output  BW  I-cache block; word k at bits [32k+31:32k]
d_req  input  1  D-cache request; held until d_ack
d_we  input  1  1 = block writeback, 0 = block read
d_addr  input  32  D-cache byte address (offset bits ignored)
d_wdata  input  BW  writeback block, same word packing
d_ack  output  1  one-cycle pulse: D-cache transaction complete
d_rdata  output  BW  D-cache read block
mem_req  output  1  memory word access valid
mem_we  output  1  memory word write
mem_addr  output  32  word byte-address
mem_wdata  output  32  write word
mem_rdata  input  32  read word, valid when mem_ready
mem_ready  input  1  current word accepted/complete this cycle
busy  output  1  1 in any state other than IDLE

Behaviour:
- Reset (async, reset==0): state=IDLE; word index=0; last_grant=I. All outputs are 0, including i_rdata/d_rdata and the latched addr/we/wdata. Any burst in progress is abandoned and no ack is issued.
- FSM states are IDLE, XFER and DONE.
- IDLE: requests are sampled at the clock edge.
  - Only one request pending: that requester is granted.
  - Both pending: the requester not equal to last_grant wins. After reset, D wins first.
  - On grant: latch owner; block base = {addr[31:OFF], OFF'b0}; we (forced to 0 for I); wdata (D only); set last_grant=owner; index=0; go to XFER.
  - No request: stay in IDLE.
- XFER:
  - Outputs: mem_req=1; mem_we=latched we; mem_addr = base + 4*index; mem_wdata = latched wdata word[index] on writes, 0 on reads.
  - All of these hold stable until mem_ready.
  - On mem_ready with a read: capture mem_rdata into the owner's rdata word[index].
  - On mem_ready: if index==BLOCK_WORDS-1, go to DONE; else index+1.
  - Zero-wait memory (mem_ready tied 1) completes one word per cycle.
- DONE: mem_req=0; owner's ack=1 for exactly this cycle; next state IDLE. The owner's rdata is complete and stable from this cycle until that owner's next read capture.
- Latency: a request sampled in IDLE at edge t gives mem_req in cycles t+1..t+N (N = BLOCK_WORDS plus wait cycles) and ack in cycle t+N+1. Minimum is BLOCK_WORDS+2 cycles from req to the cycle after ack.
- The requester drops req on the edge that ends its ack cycle, or keeps it high to start a new transaction. In that case the returning IDLE cycle re-arbitrates, so round-robin alternates under continuous contention.
- Writes leave d_rdata unchanged. A non-owner's rdata and ack are never disturbed.
- Request inputs are ignored outside IDLE. Changes to addr/wdata/we after grant have no effect.
- Dropping req mid-burst is a protocol violation. The burst still completes and ack is still pulsed.
- i_ack and d_ack are never high together. mem_req is never high in IDLE or DONE.

Decomposition:
- The state encodings (IDLE/XFER/DONE) and the owner encoding (OWN_I=0, OWN_D=1) go in the shared constants header.
- The BLOCK_WORDS default goes in the shared config header, alongside the cache geometry.
- One sub-module, arb_rr2: a 2-requester round-robin picker. Inputs are req[1:0] and last_grant; outputs are the grant valid and the owner (combinational). The last_grant register stays in l1_mem_arbiter.

Test Plan:
1. D read alone: d_addr=0x0000_1234, mem_ready=1, mem_rdata=0xA0,0xA1,0xA2,0xA3 → mem_addr=0x1230,0x1234,0x1238,0x123C in consecutive cycles, mem_we=0. d_ack pulses 1 cycle after the last word, with d_rdata={0xA3,0xA2,0xA1,0xA0}. i_ack stays 0.
2. Contention from reset: i_req=d_req=1 at the same edge, both held → D served first, then I, then D again. Acks alternate; busy=0 only for the single IDLE cycle between transactions.
3. D writeback with waits: d_we=1, d_wdata={4,3,2,1}, addr 0x2000, mem_ready high every 3rd cycle → mem_we=1, mem_wdata=1,2,3,4. mem_addr/mem_wdata hold for 3 cycles each; d_ack arrives 12 cycles after XFER entry; d_rdata unchanged.
4. Reset mid-burst: I read at 0x0040, reset=0 during word 2 → all outputs 0 immediately and no i_ack. After release, a new I request restarts at mem_addr=0x0040 and D would win a simultaneous request.
5. Input churn: change d_addr to 0xFFFF_0000 and toggle d_we during an active D read burst → mem_addr continues base+4k of the original address and mem_we stays 0.
6. Back-to-back single requester: i_req held high across two transactions with i_addr changed to 0x0080 in the ack cycle → second burst uses 0x0080..0x008C and starts 1 cycle after the first ack.
